// File: rtl/instr_encoder.sv
// instr_encoder: turns a decoded request (kind + register fields + immediate)
// into RV32 machine words. LI expands to ADDI, LUI, or LUI+ADDI. Illegal
// immediates and FENCE variants are accepted, dropped, and latched into err_o.
module instr_encoder (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_v_i,
    output logic        req_ready_o,
    input  logic [2:0]  req_kind_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [31:0] imm_i,
    output logic        instr_v_o,
    output logic [31:0] instr_o,
    input  logic        instr_ready_i,
    output logic        err_o
);

    localparam logic [2:0] KIND_OP     = 3'd0;
    localparam logic [2:0] KIND_OP_IMM = 3'd1;
    localparam logic [2:0] KIND_LOAD   = 3'd2;
    localparam logic [2:0] KIND_STORE  = 3'd3;
    localparam logic [2:0] KIND_BRANCH = 3'd4;
    localparam logic [2:0] KIND_JAL    = 3'd5;
    localparam logic [2:0] KIND_LI     = 3'd6;
    localparam logic [2:0] KIND_FENCE  = 3'd7;

    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_SEND_LUI
    } state_t;

    state_t      state_reg;
    logic [31:0] instr_reg;
    logic [31:0] pend_reg;
    logic        err_reg;

    logic        fits_i;
    logic        fits_b;
    logic        fits_j;
    logic [19:0] li_hi;
    logic [31:0] enc_word;
    logic [31:0] enc_addi;
    logic        enc_two;
    logic        enc_err;
    logic        req_fire;

    // Immediate range checks: a value fits N signed bits when all bits above
    // the sign bit replicate it. B/J offsets must also be even.
    assign fits_i = (&imm_i[31:11]) | ~(|imm_i[31:11]);
    assign fits_b = ((&imm_i[31:12]) | ~(|imm_i[31:12])) & ~imm_i[0];
    assign fits_j = ((&imm_i[31:20]) | ~(|imm_i[31:20])) & ~imm_i[0];

    // Upper part for LUI, rounded so the sign-extended ADDI low part lands
    // back on imm; (imm + 0x800)[31:12] equals imm[31:12] plus imm[11].
    assign li_hi = imm_i[31:12] + {19'd0, imm_i[11]};

    // Combinational encoder for the request currently on the input
    always_comb begin
        enc_word = '0;
        enc_addi = '0;
        enc_two  = 1'b0;
        enc_err  = 1'b0;
        case (req_kind_i)
            KIND_OP: begin
                enc_word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, OPC_OP};
            end
            KIND_OP_IMM: begin
                enc_err  = ~fits_i;
                enc_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_OP_IMM};
            end
            KIND_LOAD: begin
                enc_err  = ~fits_i;
                enc_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_LOAD};
            end
            KIND_STORE: begin
                enc_err  = ~fits_i;
                enc_word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OPC_STORE};
            end
            KIND_BRANCH: begin
                enc_err  = ~fits_b;
                enc_word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                            imm_i[4:1], imm_i[11], OPC_BRANCH};
            end
            KIND_JAL: begin
                enc_err  = ~fits_j;
                enc_word = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OPC_JAL};
            end
            KIND_LI: begin
                if (fits_i) begin
                    enc_word = {imm_i[11:0], 5'd0, 3'b000, rd_i, OPC_OP_IMM};
                end else begin
                    enc_word = {li_hi, rd_i, OPC_LUI};
                    enc_addi = {imm_i[11:0], rd_i, 3'b000, rd_i, OPC_OP_IMM};
                    enc_two  = |imm_i[11:0];
                end
            end
            KIND_FENCE: begin
                if (funct3_i == 3'b000) begin
                    enc_word = {4'b0000, imm_i[7:0], 5'd0, 3'b000, 5'd0, OPC_MISC_MEM};
                end else if (funct3_i == 3'b001) begin
                    enc_word = 32'h0000_100F;
                end else begin
                    enc_err = 1'b1;
                end
            end
            default: begin
                enc_err = 1'b1;
            end
        endcase
    end

    // A new request can enter when the output is empty or being drained this
    // cycle; nothing is accepted while reset is held.
    assign req_ready_o = ~reset_i &
                         ((state_reg == ST_IDLE) | ((state_reg == ST_SEND) & instr_ready_i));
    assign req_fire    = req_v_i & req_ready_o;

    // Output FSM: holds one word, or a LUI with its ADDI queued behind it
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg <= ST_IDLE;
            instr_reg <= '0;
            pend_reg  <= '0;
            err_reg   <= 1'b0;
        end else begin
            if (req_fire && enc_err) begin
                err_reg <= 1'b1;
            end
            case (state_reg)
                ST_SEND_LUI: begin
                    if (instr_ready_i) begin
                        state_reg <= ST_SEND;
                        instr_reg <= pend_reg;
                    end
                end
                default: begin
                    if (req_fire) begin
                        if (enc_err) begin
                            state_reg <= ST_IDLE;
                        end else if (enc_two) begin
                            state_reg <= ST_SEND_LUI;
                            instr_reg <= enc_word;
                            pend_reg  <= enc_addi;
                        end else begin
                            state_reg <= ST_SEND;
                            instr_reg <= enc_word;
                        end
                    end else if ((state_reg == ST_SEND) && instr_ready_i) begin
                        state_reg <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign instr_v_o = (state_reg != ST_IDLE);
    assign instr_o   = instr_reg;
    assign err_o     = err_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a table of single-request encodings,
// then hand-written sequences for LI expansion, streaming, stalls and reset.
module tb_instr_encoder;

    logic        clk_i;
    logic        reset_i;
    logic        req_v_i;
    logic        req_ready_o;
    logic [2:0]  req_kind_i;
    logic [4:0]  rd_i;
    logic [4:0]  rs1_i;
    logic [4:0]  rs2_i;
    logic [2:0]  funct3_i;
    logic [6:0]  funct7_i;
    logic [31:0] imm_i;
    logic        instr_v_o;
    logic [31:0] instr_o;
    logic        instr_ready_i;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    instr_encoder dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .req_v_i       (req_v_i),
        .req_ready_o   (req_ready_o),
        .req_kind_i    (req_kind_i),
        .rd_i          (rd_i),
        .rs1_i         (rs1_i),
        .rs2_i         (rs2_i),
        .funct3_i      (funct3_i),
        .funct7_i      (funct7_i),
        .imm_i         (imm_i),
        .instr_v_o     (instr_v_o),
        .instr_o       (instr_o),
        .instr_ready_i (instr_ready_i),
        .err_o         (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [2:0]  kind;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        err;
        logic [31:0] word;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'd0, act}, {31'd0, exp});
    endtask

    task automatic set_req(input logic [2:0] kind, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [31:0] imm);
        req_kind_i = kind;
        rd_i       = rd;
        rs1_i      = rs1;
        rs2_i      = rs2;
        funct3_i   = f3;
        funct7_i   = f7;
        imm_i      = imm;
    endtask

    task automatic do_reset();
        reset_i       = 1'b1;
        req_v_i       = 1'b0;
        instr_ready_i = 1'b0;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        reset_i = 1'b0;
    endtask

    function automatic logic [31:0] op_word(input logic [4:0] rd);
        return 32'h0020_8033 | {20'd0, rd, 7'd0};
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        //            kind  rd     rs1    rs2    f3     f7      imm            err   word
        vecs[0]  = '{3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0000_0000, 1'b0, 32'h0020_81B3};
        vecs[1]  = '{3'd0, 5'd5, 5'd6, 5'd7, 3'd0, 7'h20, 32'h0000_0000, 1'b0, 32'h4073_02B3};
        vecs[2]  = '{3'd1, 5'd1, 5'd2, 5'd9, 3'd0, 7'h7F, 32'hFFFF_FFFF, 1'b0, 32'hFFF1_0093};
        vecs[3]  = '{3'd1, 5'd1, 5'd0, 5'd9, 3'd0, 7'h00, 32'h0000_07FF, 1'b0, 32'h7FF0_0093};
        vecs[4]  = '{3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_F800, 1'b0, 32'h8000_0093};
        vecs[5]  = '{3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0800, 1'b1, 32'h0000_0000};
        vecs[6]  = '{3'd2, 5'd4, 5'd2, 5'd0, 3'd2, 7'h00, 32'h0000_0008, 1'b0, 32'h0081_2203};
        vecs[7]  = '{3'd3, 5'd7, 5'd2, 5'd3, 3'd2, 7'h00, 32'h0000_000C, 1'b0, 32'h0031_2623};
        vecs[8]  = '{3'd3, 5'd0, 5'd2, 5'd3, 3'd2, 7'h00, 32'hFFFF_F7FF, 1'b1, 32'h0000_0000};
        vecs[9]  = '{3'd4, 5'd9, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFF_FFFC, 1'b0, 32'hFE20_8EE3};
        vecs[10] = '{3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0000_0003, 1'b1, 32'h0000_0000};
        vecs[11] = '{3'd4, 5'd0, 5'd1, 5'd2, 3'd1, 7'h00, 32'h0000_0FFE, 1'b0, 32'h7E20_9FE3};
        vecs[12] = '{3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0000_1000, 1'b1, 32'h0000_0000};
        vecs[13] = '{3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFF_F000, 1'b0, 32'h8020_8063};
        vecs[14] = '{3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0800, 1'b0, 32'h0010_00EF};
        vecs[15] = '{3'd5, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFE, 1'b0, 32'hFFFF_F06F};
        vecs[16] = '{3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h000F_FFFE, 1'b0, 32'h7FFF_F0EF};
        vecs[17] = '{3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0010_0000, 1'b1, 32'h0000_0000};
        vecs[18] = '{3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0001, 1'b1, 32'h0000_0000};
        vecs[19] = '{3'd7, 5'd5, 5'd5, 5'd0, 3'd0, 7'h00, 32'h0000_00FF, 1'b0, 32'h0FF0_000F};
        vecs[20] = '{3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h000A_BC33, 1'b0, 32'h0330_000F};
        vecs[21] = '{3'd7, 5'd3, 5'd4, 5'd0, 3'd1, 7'h00, 32'h0000_00FF, 1'b0, 32'h0000_100F};
        vecs[22] = '{3'd7, 5'd0, 5'd0, 5'd0, 3'd2, 7'h00, 32'h0000_0000, 1'b1, 32'h0000_0000};
        vecs[23] = '{3'd6, 5'd7, 5'd3, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFB, 1'b0, 32'hFFB0_0393};
        vecs[24] = '{3'd6, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_1000, 1'b0, 32'h0000_10B7};
        vecs[25] = '{3'd6, 5'd2, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_07FF, 1'b0, 32'h7FF0_0113};
        vecs[26] = '{3'd6, 5'd2, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_F000, 1'b0, 32'hFFFF_F137};
        vecs[27] = '{3'd5, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFF0_0000, 1'b0, 32'h8000_006F};

        set_req(3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        req_v_i       = 1'b0;
        instr_ready_i = 1'b0;
        reset_i       = 1'b1;

        // Reset state
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        chk1("rst_valid", instr_v_o, 1'b0);
        chk("rst_instr", instr_o, 32'h0);
        chk1("rst_err", err_o, 1'b0);
        chk1("rst_ready", req_ready_o, 1'b0);
        reset_i = 1'b0;
        #1;
        chk1("idle_ready", req_ready_o, 1'b1);

        // Table of single-request encodings
        for (int i = 0; i < NV; i++) begin
            do_reset();
            set_req(vecs[i].kind, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                    vecs[i].f3, vecs[i].f7, vecs[i].imm);
            req_v_i = 1'b1;
            @(posedge clk_i); #1;
            req_v_i = 1'b0;
            $display("vec %0d kind %0d imm %h -> valid %0d word %h err %0d",
                     i, vecs[i].kind, vecs[i].imm, instr_v_o, instr_o, err_o);
            chk1($sformatf("v%0d_valid", i), instr_v_o, ~vecs[i].err);
            chk1($sformatf("v%0d_err", i), err_o, vecs[i].err);
            if (!vecs[i].err) begin
                chk($sformatf("v%0d_word", i), instr_o, vecs[i].word);
            end
            instr_ready_i = 1'b1;
            @(posedge clk_i); #1;
            chk1($sformatf("v%0d_drain", i), instr_v_o, 1'b0);
            instr_ready_i = 1'b0;
        end

        // LI two-word expansion with a stall on the LUI
        do_reset();
        set_req(3'd6, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5678);
        req_v_i = 1'b1;
        @(posedge clk_i); #1;
        req_v_i = 1'b0;
        $display("li 0x12345678 rd5 -> %h", instr_o);
        chk1("li1_lui_valid", instr_v_o, 1'b1);
        chk("li1_lui", instr_o, 32'h1234_52B7);
        chk1("li1_lui_ready", req_ready_o, 1'b0);
        @(posedge clk_i); #1;
        chk("li1_lui_hold", instr_o, 32'h1234_52B7);
        instr_ready_i = 1'b1;
        #1;
        chk1("li1_lui_ready_hs", req_ready_o, 1'b0);
        @(posedge clk_i); #1;
        $display("li 0x12345678 rd5 -> %h", instr_o);
        chk("li1_addi", instr_o, 32'h6782_8293);
        chk1("li1_addi_valid", instr_v_o, 1'b1);
        chk1("li1_addi_ready", req_ready_o, 1'b1);
        @(posedge clk_i); #1;
        chk1("li1_done", instr_v_o, 1'b0);

        // LI with wrap of the upper part, continuous ready
        do_reset();
        instr_ready_i = 1'b1;
        set_req(3'd6, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h7FFF_F800);
        req_v_i = 1'b1;
        @(posedge clk_i); #1;
        req_v_i = 1'b0;
        $display("li 0x7ffff800 rd1 -> %h", instr_o);
        chk("li2_lui", instr_o, 32'h8000_00B7);
        @(posedge clk_i); #1;
        $display("li 0x7ffff800 rd1 -> %h", instr_o);
        chk("li2_addi", instr_o, 32'h8000_8093);
        chk1("li2_addi_valid", instr_v_o, 1'b1);
        @(posedge clk_i); #1;
        chk1("li2_done", instr_v_o, 1'b0);

        // Back-to-back OP stream, then a 3-cycle consumer stall
        do_reset();
        instr_ready_i = 1'b1;
        req_v_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            set_req(3'd0, 5'(k), 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
            @(posedge clk_i); #1;
            $display("stream op rd%0d -> %h", k, instr_o);
            chk($sformatf("b2b_word%0d", k), instr_o, op_word(5'(k)));
            chk1($sformatf("b2b_valid%0d", k), instr_v_o, 1'b1);
            chk1($sformatf("b2b_ready%0d", k), req_ready_o, 1'b1);
        end
        set_req(3'd0, 5'd9, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        instr_ready_i = 1'b0;
        #1;
        chk1("stall_ready0", req_ready_o, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_i); #1;
            chk($sformatf("stall_hold%0d", k), instr_o, op_word(5'd4));
            chk1($sformatf("stall_ready%0d", k), req_ready_o, 1'b0);
            chk1($sformatf("stall_valid%0d", k), instr_v_o, 1'b1);
        end
        instr_ready_i = 1'b1;
        @(posedge clk_i); #1;
        req_v_i = 1'b0;
        $display("stream op rd9 -> %h", instr_o);
        chk("stall_resume", instr_o, op_word(5'd9));
        @(posedge clk_i); #1;
        chk1("stream_done", instr_v_o, 1'b0);

        // Reset while the ADDI is pending
        do_reset();
        set_req(3'd6, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5678);
        req_v_i = 1'b1;
        @(posedge clk_i); #1;
        req_v_i = 1'b0;
        chk("rl_lui", instr_o, 32'h1234_52B7);
        reset_i = 1'b1;
        instr_ready_i = 1'b1;
        @(posedge clk_i); #1;
        chk1("rl_valid", instr_v_o, 1'b0);
        chk("rl_instr", instr_o, 32'h0);
        reset_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_i); #1;
            chk1($sformatf("rl_quiet%0d", k), instr_v_o, 1'b0);
        end
        $display("reset in send_lui -> valid %0d", instr_v_o);

        // SEND into SEND_LUI, then an error accepted on a SEND handshake
        do_reset();
        set_req(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        req_v_i = 1'b1;
        @(posedge clk_i); #1;
        chk("ch_op", instr_o, op_word(5'd3));
        set_req(3'd6, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5678);
        instr_ready_i = 1'b1;
        #1;
        chk1("ch_ready", req_ready_o, 1'b1);
        @(posedge clk_i); #1;
        req_v_i = 1'b0;
        chk("ch_lui", instr_o, 32'h1234_52B7);
        @(posedge clk_i); #1;
        chk("ch_addi", instr_o, 32'h6782_8293);
        chk1("ch_err_before", err_o, 1'b0);
        set_req(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0000_0003);
        req_v_i = 1'b1;
        @(posedge clk_i); #1;
        req_v_i = 1'b0;
        $display("branch imm 3 on handshake -> valid %0d err %0d", instr_v_o, err_o);
        chk1("ch_err_idle", instr_v_o, 1'b0);
        chk1("ch_err_set", err_o, 1'b1);
        set_req(3'd0, 5'd4, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        req_v_i = 1'b1;
        @(posedge clk_i); #1;
        req_v_i = 1'b0;
        chk("ch_after_err", instr_o, op_word(5'd4));
        chk1("ch_err_sticky1", err_o, 1'b1);
        @(posedge clk_i); #1;
        chk1("ch_err_sticky2", err_o, 1'b1);
        chk1("ch_final_idle", instr_v_o, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
